// File: rtl/single_seven_segment_display_pkg.sv
// Shared constants for the single-digit seven-segment display.
// The segment patterns are active low and written {g,f,e,d,c,b,a}.
package single_seven_segment_display_pkg;
   localparam int DEFAULT_CLK_FREQ_HZ = 100_000_000;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [7:0] AN_DIGIT0 = 8'hFE;
endpackage

// File: rtl/single_seven_segment_display_top_seg7_decoder.sv
// Combinational BCD digit to active-low cathode decoder.
// Codes 10-15 blank the digit.
module seg7_decoder
   import single_seven_segment_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/single_seven_segment_display_top.sv
// Nexys4 DDR top: divides clk to a 1 Hz square wave and counts 0-9 on its
// rising edges, showing the digit on AN0.
module single_seven_segment_display_top
   import single_seven_segment_display_pkg::*;
#(
   parameter int CLK_FREQ_HZ        = DEFAULT_CLK_FREQ_HZ,
   parameter int TICK_HZ            = 1,
   parameter int HALF_PERIOD_CYCLES = CLK_FREQ_HZ / (2 * TICK_HZ),
   parameter int DIGIT_MAX          = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic [6:0] ssdCathode,
   output logic [7:0] ssdAnode,
   output logic       clk_1Hz_reg
);
   localparam int CNT_W = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD_CYCLES - 1);
   localparam logic [3:0]       DIG_LAST = 4'(DIGIT_MAX);

   // Power-up values match reset so the board shows 0 without a reset press.
   logic [CNT_W-1:0] count     = '0;
   logic             tick_q    = 1'b0;
   logic [3:0]       digit     = 4'd0;

   logic terminal;
   logic rise;

   assign terminal = enable && (count == CNT_LAST);
   // The square wave goes 0->1 on this edge; it drives the digit as an enable.
   assign rise     = terminal && !tick_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         tick_q <= 1'b0;
      end else if (terminal) begin
         count  <= '0;
         tick_q <= ~tick_q;
      end else if (enable) begin
         count  <= count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         digit <= 4'd0;
      end else if (rise) begin
         digit <= (digit == DIG_LAST) ? 4'd0 : digit + 4'd1;
      end
   end

   seg7_decoder u_dec (
      .digit (digit),
      .seg   (ssdCathode)
   );

   assign ssdAnode    = AN_DIGIT0;
   assign clk_1Hz_reg = tick_q;
endmodule

// File: tb/tb_single_seven_segment_display_top.sv
// Randomised bench for the seven-segment top against a tick-count model.
module tb_single_seven_segment_display_top;
   localparam int H = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [6:0] ssdCathode;
   logic [7:0] ssdAnode;
   logic       clk_1Hz_reg;

   single_seven_segment_display_top #(.HALF_PERIOD_CYCLES(H)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .ssdCathode  (ssdCathode),
      .ssdAnode    (ssdAnode),
      .clk_1Hz_reg (clk_1Hz_reg)
   );

   always #5 clk = ~clk;

   logic [6:0] pat [0:9];
   int ticks = 0;   // enabled, non-reset edges since the last reset
   int total = 0;
   int bad   = 0;

   function automatic int m_clk();
      return (ticks / H) % 2;
   endfunction

   // Rises happen at ticks H, 3H, 5H ...; the digit is the number of rises mod 10.
   function automatic int m_digit();
      return ((ticks + H) / (2 * H)) % 10;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t ticks=%0d)", name, act, exp, $time, ticks);
      end
   endtask

   task automatic step();
      bit legal;
      @(posedge clk);
      if (reset) ticks = 0;
      else if (enable) ticks++;
      @(negedge clk);
      chk("clk_1Hz", 32'(clk_1Hz_reg), 32'(m_clk()));
      chk("cathode", 32'(ssdCathode), 32'(pat[m_digit()]));
      chk("anode", 32'(ssdAnode), 32'hFE);
      legal = 1'b0;
      for (int i = 0; i < 10; i++) if (ssdCathode === pat[i]) legal = 1'b1;
      chk("cathode_legal", 32'(legal), 32'd1);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int guard;
      pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
      pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
      pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
      pat[9] = 7'b0010000;

      // power-up, no reset
      enable = 1'b1;
      #1;
      chk("pwr_clk", 32'(clk_1Hz_reg), 32'd0);
      chk("pwr_cath", 32'(ssdCathode), 32'h40);
      chk("pwr_anode", 32'(ssdAnode), 32'hFE);

      steps(4);
      chk("lit_e4_clk", 32'(clk_1Hz_reg), 32'd0);
      step();
      chk("lit_e5_clk", 32'(clk_1Hz_reg), 32'd1);
      chk("lit_e5_cath", 32'(ssdCathode), 32'h79);
      steps(5);
      chk("lit_e10_clk", 32'(clk_1Hz_reg), 32'd0);
      steps(75);
      chk("lit_e85_cath9", 32'(ssdCathode), 32'h10);
      steps(10);
      chk("lit_e95_wrap", 32'(ssdCathode), 32'h40);
      steps(5);

      // freeze 17 cycles two edges into a half period
      steps(2);
      enable = 1'b0;
      steps(17);
      chk("frz_hold_clk", 32'(clk_1Hz_reg), 32'd0);
      enable = 1'b1;
      steps(2);
      chk("frz_e2_clk", 32'(clk_1Hz_reg), 32'd0);
      step();
      chk("frz_e3_clk", 32'(clk_1Hz_reg), 32'd1);

      // reset at digit 6, count 3
      guard = 0;
      while (!(m_digit() == 6 && ticks % H == 3) && guard < 200) begin
         step(); guard++;
      end
      chk("reach_d6", 32'(guard < 200), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_cath", 32'(ssdCathode), 32'h40);
      chk("rst_clk", 32'(clk_1Hz_reg), 32'd0);
      steps(4);
      chk("rst_e4_clk", 32'(clk_1Hz_reg), 32'd0);
      step();
      chk("rst_e5_clk", 32'(clk_1Hz_reg), 32'd1);

      // reset and enable together at a terminal count with clk_1Hz high
      steps(4);
      chk("pri_pre_clk", 32'(clk_1Hz_reg), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("pri_clk", 32'(clk_1Hz_reg), 32'd0);
      chk("pri_cath", 32'(ssdCathode), 32'h40);
      steps(5);
      chk("pri_e5_clk", 32'(clk_1Hz_reg), 32'd1);

      // random enable / reset traffic
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(9) < 7);
         reset  = ($urandom_range(99) < 2);
         step();
      end
      reset = 1'b0;
      enable = 1'b1;
      steps(120);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/single_seven_segment_display_top.md
Name: single_seven_segment_display_top

Overview:
- Board-level top for the Nexys4 DDR, clocked by the 100 MHz board oscillator.
- Divides the clock down to a 1 Hz square wave (`clk_1Hz_reg`) and counts decimal digits 0–9 on each 1 Hz rising edge.
- Shows the current digit on the rightmost seven-segment digit (AN0) only, with active-low anodes and cathodes.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 1, frequency of `clk_1Hz_reg`.
- HALF_PERIOD_CYCLES, CLK_FREQ_HZ/(2*TICK_HZ) = 50_000_000, clk cycles per half-period of `clk_1Hz_reg`. Benches override it to a small value.
- DIGIT_MAX, 9, last count value before wrap to 0.

Ports:
- clk  in  1  board clock, 100 MHz; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high = run the divider and counter; low = freeze both.
- ssdCathode  out  7  segment drive, active low; bit0=CA(a), bit1=CB(b) … bit6=CG(g).
- ssdAnode  out  8  digit select, active low; constant 8'b1111_1110 (AN0 only).
- clk_1Hz_reg  out  1  registered 1 Hz square wave, 50% duty cycle.

Behaviour:
- One clock domain; reset is synchronous and active-high. `clk_1Hz_reg` is never used as a clock; the digit uses a clk-domain enable.
- All registers have power-up initial values equal to their reset values, so outputs are defined even if reset is never asserted:
  - divider count = 0
  - `clk_1Hz_reg` = 0
  - digit = 0
- Reset (reset=1 at an edge) loads those values; reset takes priority over enable. A mid-operation reset restarts a full half-period.
- Divider: counter width is ceil(log2(HALF_PERIOD_CYCLES)).
  - If enable=1 and count == HALF_PERIOD_CYCLES-1: count <= 0 and `clk_1Hz_reg` toggles.
  - Otherwise, if enable=1: count increments.
  - If enable=0: count and `clk_1Hz_reg` hold.
- Digit counter, 4 bits:
  - Increments on the same edge at which `clk_1Hz_reg` goes 0→1.
  - Wraps DIGIT_MAX→0 on that edge.
  - Never increments on the 1→0 edge.
- After reset is released, with enable held high:
  - First rise of `clk_1Hz_reg` is at edge HALF_PERIOD_CYCLES; digit becomes 1 there.
  - Subsequent increments come every 2*HALF_PERIOD_CYCLES edges.
- Enable low mid-period freezes the phase. When enable returns high, counting resumes from the held count with no extra or lost tick.
- `ssdCathode` is a combinational decode of the registered digit, zero latency. Active-low patterns, written {g,f,e,d,c,b,a}:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - Codes 10–15 (unreachable) decode to 1111111, all segments off.
- `ssdAnode` is constant 8'b1111_1110 in all states, including reset. There is no decimal-point output.

Decomposition:
- Shared package:
  - Segment pattern constants SEG_0…SEG_9 and SEG_BLANK.
  - Active-low anode constant AN_DIGIT0 = 8'hFE.
  - Default CLK_FREQ_HZ.
- One natural sub-module: seg7_decoder, a purely combinational 4-bit digit → 7-bit active-low cathode decoder.
- The divider and digit counter stay in the top; together they are roughly 120–200 lines.

Test Plan (HALF_PERIOD_CYCLES=5; 10 ns clk, as in the board bench):
- Power-up, no reset, enable=1:
  - At t=0: `clk_1Hz_reg`=0, `ssdCathode`=1000000, `ssdAnode`=FE.
  - `clk_1Hz_reg` rises after 5 edges and falls after 10 edges.
- Counting: enable=1 for 100 edges → digit 0,1,…,9,0 at rise edges 5, 15, …, 95.
  - Digit 9 shows 0010000; the following rise returns to 1000000 (wrap check).
- Enable freeze: enable=0 for 17 cycles mid-half-period → `clk_1Hz_reg`, digit and count hold. The next toggle arrives exactly 17 cycles later than nominal.
- Synchronous reset: assert reset while digit=6 and count=3.
  - Next edge: digit=0, `clk_1Hz_reg`=0.
  - First rise comes 5 edges after reset deasserts.
- Reset priority: reset=1 and enable=1 together at the terminal count → no toggle and no increment; all outputs at their reset values.
- Anode invariance: over the whole run, `ssdAnode` == 8'hFE every cycle, and `ssdCathode` is always one of the ten legal patterns.
